// File: rtl/inst_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage_pkg : DLX constants and fetch state encoding
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package inst_fetch_stage_pkg;

    localparam logic [0:31] DLX_NOP_INSTR = 32'h54000000;
    localparam logic [0:31] WORD_BYTES    = 32'd4;
    localparam int          OPCODE_MSB    = 0;
    localparam int          OPCODE_LSB    = 5;

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_REDIR = 2'd2
    } fetch_state_e;

    function automatic logic [0:5] dlx_opcode(input logic [0:31] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage_if : redirect, IMEM and decode-side signals of the fetch stage
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface inst_fetch_stage_if;

    logic        redirect_valid;
    logic [0:31] redirect_target;
    logic        id_stall;
    logic        imem_en;
    logic [0:31] imem_addr;
    logic [0:31] imem_rdata;
    logic        if_valid;
    logic [0:31] if_instr;
    logic [0:31] if_pc;
    logic [0:31] if_npc;

    modport master (
        input  redirect_valid, redirect_target, id_stall, imem_rdata,
        output imem_en, imem_addr, if_valid, if_instr, if_pc, if_npc
    );

    modport slave (
        output redirect_valid, redirect_target, id_stall, imem_rdata,
        input  imem_en, imem_addr, if_valid, if_instr, if_pc, if_npc
    );

endinterface

`default_nettype wire

// File: rtl/inst_fetch_stage_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf : one-entry instruction/PC holding register (clear beats load)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fetch_hold_buf
    import inst_fetch_stage_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        load_i,
    input  wire logic        clear_i,
    input  wire logic [0:31] instr_i,
    input  wire logic [0:31] pc_i,
    output logic             valid_o,
    output logic      [0:31] instr_o,
    output logic      [0:31] pc_o
);

    logic        valid_q;
    logic [0:31] instr_q;
    logic [0:31] pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            instr_q <= DLX_NOP_INSTR;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage : pipelined DLX fetch front end with stall buffer and redirect
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [0:31] RESET_PC  = 32'h00000000,
    parameter logic [0:31] NOP_INSTR = DLX_NOP_INSTR
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    inst_fetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [0:31]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [0:31]  inflight_pc_q, inflight_pc_d;
    logic         start_q;
    logic         out_valid_q, out_valid_d;
    logic [0:31]  out_instr_q, out_instr_d;
    logic [0:31]  out_pc_q, out_pc_d;
    logic         buf_load, buf_clear, buf_valid;
    logic [0:31]  buf_instr, buf_pc;
    logic         stalled, issue;
    logic [0:1]   unused_tgt_lsbs;

    assign unused_tgt_lsbs = bus.redirect_target[30:31];

    // start_q keeps the partial cycle between reset release and the first edge idle
    assign stalled = bus.id_stall && out_valid_q;
    assign issue   = start_q && !stalled && !bus.redirect_valid;

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = out_valid_q;
    assign bus.if_instr  = out_valid_q ? out_instr_q : NOP_INSTR;
    assign bus.if_pc     = out_pc_q;
    assign bus.if_npc    = out_pc_q + WORD_BYTES;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (bus.imem_rdata),
        .pc_i    (inflight_pc_q),
        .valid_o (buf_valid),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            start_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= NOP_INSTR;
            out_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            start_q       <= 1'b1;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = issue ? pc_q + WORD_BYTES : pc_q;
        inflight_d    = issue;
        inflight_pc_d = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;

        if (bus.redirect_valid) begin
            pc_d        = {bus.redirect_target[0:29], 2'b00};
            buf_clear   = 1'b1;
            out_valid_d = 1'b0;
            state_d     = FETCH_REDIR;
        end else begin
            case (state_q)
                FETCH_HOLD: begin
                    // Draining the buffer while the refetch at pc_q issues avoids a bubble
                    if (!stalled) begin
                        out_valid_d = buf_valid;
                        out_instr_d = buf_instr;
                        out_pc_d    = buf_pc;
                        buf_clear   = 1'b1;
                        state_d     = FETCH_RUN;
                    end
                end
                default: begin
                    if (stalled) begin
                        if (inflight_q) begin
                            buf_load = 1'b1;
                            state_d  = FETCH_HOLD;
                        end
                    end else begin
                        out_valid_d = inflight_q;
                        if (inflight_q) begin
                            out_instr_d = bus.imem_rdata;
                            out_pc_d    = inflight_pc_q;
                        end
                        state_d = FETCH_RUN;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_stage : directed vector bench for inst_fetch_stage
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_stage;

    localparam logic [31:0] NOP = 32'h54000000;

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [31:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    inst_fetch_stage_if bus ();

    inst_fetch_stage #(
        .RESET_PC  (32'h00000000),
        .NOP_INSTR (32'h54000000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h20010000 + (a >> 2);
    endfunction

    always @(posedge clk)
        bus.imem_rdata <= bus.imem_en ? mem_word(bus.imem_addr) : 32'hDEADBEEF;

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] tg,
                                input logic v, input logic [31:0] pc,
                                input logic en, input logic [31:0] addr);
        vec_t r;
        r.stall = st; r.redir = rd; r.tgt = tg;
        r.exp_valid = v; r.exp_pc = pc; r.exp_en = en; r.exp_addr = addr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, " if_valid"}, {31'd0, bus.if_valid}, {31'd0, v});
        if (v) begin
            chk({tag, " if_pc"},    bus.if_pc,    pc);
            chk({tag, " if_instr"}, bus.if_instr, mem_word(pc));
            chk({tag, " if_npc"},   bus.if_npc,   pc + 32'd4);
        end else begin
            chk({tag, " if_instr nop"}, bus.if_instr, NOP);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic en, input logic [31:0] addr);
        chk({tag, " imem_en"}, {31'd0, bus.imem_en}, {31'd0, en});
        if (en) chk({tag, " imem_addr"}, bus.imem_addr, addr);
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tg);
        bus.id_stall        = st;
        bus.redirect_valid  = rd;
        bus.redirect_target = tg;
    endtask

    task automatic cyc(input logic st, input logic rd, input logic [31:0] tg);
        @(negedge clk);
        drive(st, rd, tg);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " if_valid"}, {31'd0, bus.if_valid}, 32'd0);
        chk({tag, " if_instr"}, bus.if_instr, NOP);
        chk({tag, " if_pc"},    bus.if_pc,    32'd0);
        chk({tag, " if_npc"},   bus.if_npc,   32'd4);
        chk({tag, " imem_en"},  {31'd0, bus.imem_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // stall, redir, target | valid, if_pc | imem_en, imem_addr  (cycle 0 = after first edge)
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h4);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 32'h8);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'hC);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h10);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h10);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h10);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h10);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h14);
        vecs[9]  = mk(1'b0, 1'b1, 32'h102, 1'b1, 32'h10,  1'b0, 32'h18);
        vecs[10] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h108);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h10C);

        drive(1'b0, 1'b0, 32'h0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_state("reset");
        reset_n = 1'b1;
        #1;
        chk("pre-first-edge imem_en", {31'd0, bus.imem_en}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].stall, vecs[i].redir, vecs[i].tgt);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            chk_fetch($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_addr);
        end

        // Redirect together with stall while HOLD owns a buffered instruction
        cyc(1'b1, 1'b0, 32'h0);
        chk_out("holdA c14", 1'b1, 32'h108);
        chk_fetch("holdA c14", 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h40);
        chk_out("holdA c15", 1'b1, 32'h108);
        chk_fetch("holdA c15", 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk_out("holdA c16", 1'b0, 32'h0);
        chk_fetch("holdA c16", 1'b1, 32'h40);
        cyc(1'b1, 1'b0, 32'h0);
        chk_out("holdA c17", 1'b0, 32'h0);
        chk_fetch("holdA c17", 1'b1, 32'h44);
        cyc(1'b0, 1'b0, 32'h0);
        chk_out("holdA c18", 1'b1, 32'h40);
        cyc(1'b0, 1'b0, 32'h0);
        chk_out("holdA c19", 1'b1, 32'h44);

        // PC wrap at the top of the address space; target low bits ignored
        cyc(1'b0, 1'b1, 32'hFFFFFFFF);
        chk_fetch("wrap c20", 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk_fetch("wrap c21", 1'b1, 32'hFFFFFFFC);
        cyc(1'b0, 1'b0, 32'h0);
        chk_fetch("wrap c22", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap if_pc",    bus.if_pc,    32'hFFFFFFFC);
        chk("wrap if_npc",   bus.if_npc,   32'h00000000);
        chk("wrap if_instr", bus.if_instr, 32'h6000FFFF);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap next if_pc",    bus.if_pc,    32'h0);
        chk("wrap next if_instr", bus.if_instr, 32'h20010000);

        // Asynchronous reset while HOLD has a buffered instruction
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk_fetch("rstC hold", 1'b0, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_state("mid reset");
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("rstC pre-edge imem_en", {31'd0, bus.imem_en}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0);
        chk_out("rstC c0", 1'b0, 32'h0);
        chk_fetch("rstC c0", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk_out("rstC c1", 1'b0, 32'h0);
        chk_fetch("rstC c1", 1'b1, 32'h4);
        cyc(1'b0, 1'b0, 32'h0);
        chk_out("rstC c2", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk_out("rstC c3", 1'b1, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
